// File: rtl/uart_rx_fsm_if.sv
// ----------------------------------------------------------------------------
// uart_rx_fsm_if
//   Bundles the UART RX control/datapath signals between the receive FSM,
//   its companion edge/bit counter, the RX pin and the data consumer.
//
//   RX_IN         serial line, synchronised, idle high
//   ParityEn      1 = frame carries a parity bit
//   ParityType    0 = even, 1 = odd
//   BitCounter    bit index from the counter (0 = start .. 10)
//   EdgeCounter   cycle index within the current bit (0..7)
//   CounterEnable enable to the edge/bit counter
//   P_DATA        received byte
//   DataValid     one-cycle pulse for a good frame
//   ParityError   parity mismatch in the last frame
//   StopError     stop bit sampled 0 in the last frame
//
//   slave  : the receive FSM side
//   master : the environment driving line, configuration and counter
// ----------------------------------------------------------------------------
interface uart_rx_fsm_if;
    logic       RX_IN;
    logic       ParityEn;
    logic       ParityType;
    logic [3:0] BitCounter;
    logic [4:0] EdgeCounter;
    logic       CounterEnable;
    logic [7:0] P_DATA;
    logic       DataValid;
    logic       ParityError;
    logic       StopError;

    modport slave (
        input  RX_IN, ParityEn, ParityType, BitCounter, EdgeCounter,
        output CounterEnable, P_DATA, DataValid, ParityError, StopError
    );

    modport master (
        output RX_IN, ParityEn, ParityType, BitCounter, EdgeCounter,
        input  CounterEnable, P_DATA, DataValid, ParityError, StopError
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// ----------------------------------------------------------------------------
// uart_rx_fsm
//   Receive-side control and datapath of the UART RX. Detects the start bit,
//   enables the companion edge/bit counter, majority-samples RX_IN mid-bit,
//   deserializes 8 data bits LSB-first, checks parity and stop, and pulses
//   DataValid for a good frame.
//
//   CLK  system clock, rising edge
//   RST  asynchronous active-low reset
//   bus  uart_rx_fsm_if.slave: RX_IN, ParityEn, ParityType, BitCounter,
//        EdgeCounter in; CounterEnable, P_DATA, DataValid, ParityError,
//        StopError out
//
//   Optional feature macro: RX_GLITCH_FILTER_EN
//     Defined   : a start bit sampled as 1 is treated as a false start and
//                 the frame is flushed (FLUSH state) without flags or data.
//     Undefined : START always proceeds to DATA; FLUSH is not built.
// ----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int unsigned PRESCALE   = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic          CLK,
    input logic          RST,
    uart_rx_fsm_if.slave bus
);

    localparam logic [4:0] EDGE_S0   = 5'(PRESCALE / 2 - 1);
    localparam logic [4:0] EDGE_S1   = 5'(PRESCALE / 2);
    localparam logic [4:0] EDGE_S2   = 5'(PRESCALE / 2 + 1);
    localparam logic [4:0] EDGE_LAST = 5'(PRESCALE - 1);
    localparam logic [3:0] BIT_LAST_DATA = 4'(DATA_WIDTH);
`ifdef RX_GLITCH_FILTER_EN
    localparam logic [3:0] BIT_STOP_NOPAR = 4'(DATA_WIDTH + 1);
    localparam logic [3:0] BIT_STOP_PAR   = 4'(DATA_WIDTH + 2);
`endif

`ifdef RX_GLITCH_FILTER_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, FLUSH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t                  state_q, state_d;
    logic                    ce_q;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    dv_q, dv_d;
    logic                    perr_q, perr_d;
    logic                    serr_q, serr_d;
    logic [2:0]              samp_q;
    logic                    bit_val;
    logic                    edge_last;

    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);
    assign edge_last = (bus.EdgeCounter == EDGE_LAST);

    // Three mid-bit samples; the counter sits at 0 while idle, so no
    // state qualification is needed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_q <= '0;
        end else begin
            if (bus.EdgeCounter == EDGE_S0) samp_q[0] <= bus.RX_IN;
            if (bus.EdgeCounter == EDGE_S1) samp_q[1] <= bus.RX_IN;
            if (bus.EdgeCounter == EDGE_S2) samp_q[2] <= bus.RX_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            ce_q     <= 1'b0;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ce_q     <= (state_d != IDLE);
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            perr_q   <= perr_d;
            serr_q   <= serr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        perr_d   = perr_q;
        serr_d   = serr_q;
        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                end
            end
            START: begin
                if (edge_last && bus.BitCounter == 4'd0) begin
`ifdef RX_GLITCH_FILTER_EN
                    state_d = bit_val ? FLUSH : DATA;
`else
                    state_d = DATA;
`endif
                end
            end
            DATA: begin
                if (edge_last) begin
                    p_data_d = {bit_val, p_data_q[DATA_WIDTH-1:1]};
                    if (bus.BitCounter == BIT_LAST_DATA)
                        state_d = bus.ParityEn ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_last) begin
                    perr_d  = (bit_val != (^p_data_q ^ bus.ParityType));
                    state_d = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    serr_d  = ~bit_val;
                    dv_d    = bit_val & ~perr_q;
                    state_d = IDLE;
                end
            end
`ifdef RX_GLITCH_FILTER_EN
            FLUSH: begin
                if (edge_last && bus.BitCounter ==
                        (bus.ParityEn ? BIT_STOP_PAR : BIT_STOP_NOPAR))
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.CounterEnable = ce_q;
    assign bus.P_DATA        = p_data_q;
    assign bus.DataValid     = dv_q;
    assign bus.ParityError   = perr_q;
    assign bus.StopError     = serr_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fsm
//   Builds a per-cycle RX line waveform (directed plus $urandom frames),
//   decodes it with a frame-level reference model, then drives the DUT with
//   a behavioural edge/bit counter and compares every cycle.
// ----------------------------------------------------------------------------
module tb_uart_rx_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_fsm_if bus ();

    uart_rx_fsm #(.PRESCALE(8), .DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Companion edge/bit counter: wraps to 0/0 at the last bit of the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.EdgeCounter <= '0;
            bus.BitCounter  <= '0;
        end else if (!bus.CounterEnable) begin
            bus.EdgeCounter <= '0;
            bus.BitCounter  <= '0;
        end else if (bus.EdgeCounter == 5'd7) begin
            bus.EdgeCounter <= '0;
            bus.BitCounter  <= (bus.BitCounter == (bus.ParityEn ? 4'd10 : 4'd9))
                               ? 4'd0 : bus.BitCounter + 4'd1;
        end else begin
            bus.EdgeCounter <= bus.EdgeCounter + 5'd1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line waveform and configuration, one entry per clock edge.
    bit wave_rx[$];
    bit wave_pe[$];
    bit wave_pt[$];
    bit cur_pe = 1'b0;
    bit cur_pt = 1'b0;

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) begin
            wave_rx.push_back(1'b1);
            wave_pe.push_back(cur_pe);
            wave_pt.push_back(cur_pt);
        end
    endtask

    task automatic add_cycles(input bit v, input int n);
        for (int k = 0; k < n; k++) begin
            wave_rx.push_back(v);
            wave_pe.push_back(cur_pe);
            wave_pt.push_back(cur_pt);
        end
    endtask

    // Frame bit gbit gets one inverted cycle at offset goff (-1: none).
    task automatic add_frame(input logic [7:0] d, input bit par_flip, input bit stop_v,
                             input int gbit, input int goff);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (cur_pe) bits.push_back((^d) ^ cur_pt ^ par_flip);
        bits.push_back(stop_v);
        for (int b = 0; b < bits.size(); b++)
            for (int off = 0; off < 8; off++) begin
                wave_rx.push_back((b == gbit && off == goff) ? ~bits[b] : bits[b]);
                wave_pe.push_back(cur_pe);
                wave_pt.push_back(cur_pt);
            end
    endtask

    // Expected outputs after each clock edge.
    bit exp_ce[];
    bit exp_dv[];
    bit exp_perr[];
    bit exp_serr[];
    typedef struct { int n; logic [7:0] pd; } ev_t;
    ev_t evq[$];

    function automatic bit maj3(input int base);
        int c;
        c = int'(wave_rx[base]) + int'(wave_rx[base + 1]) + int'(wave_rx[base + 2]);
        return (c >= 2);
    endfunction

    // Frame-level decoder: a start is the first low line cycle while idle;
    // bit k is the majority of line cycles start+8k+4..+6; the result lands
    // on the edge start+8*nbits and the receiver is idle again one edge later.
    task automatic run_model();
        int n_tot, pos, i, nb;
        bit false_start, perr, serr;
        logic [7:0] data, last_pd;
        n_tot = wave_rx.size();
        exp_ce = new[n_tot]; exp_dv = new[n_tot];
        exp_perr = new[n_tot]; exp_serr = new[n_tot];
        pos = 0;
        last_pd = '0;
        forever begin
            i = pos;
            while (i < n_tot && wave_rx[i] != 1'b0) i++;
            if (i >= n_tot) break;
            nb = wave_pe[i] ? 11 : 10;
            if (i + 8 * nb >= n_tot) break;
            for (int n = i; n < i + 8 * nb; n++) exp_ce[n] = 1'b1;
            for (int n = i; n < n_tot; n++) begin exp_perr[n] = 1'b0; exp_serr[n] = 1'b0; end
            false_start = 1'b0;
`ifdef RX_GLITCH_FILTER_EN
            false_start = maj3(i + 4);
`endif
            if (!false_start) begin
                for (int k = 1; k <= 8; k++) data[k - 1] = maj3(i + 8 * k + 4);
                perr = wave_pe[i] && (maj3(i + 8 * 9 + 4) != ((^data) ^ wave_pt[i]));
                for (int n = i + 80; n < n_tot; n++) exp_perr[n] = perr;
                serr = !maj3(i + 8 * (nb - 1) + 4);
                for (int n = i + 8 * nb; n < n_tot; n++) exp_serr[n] = serr;
                exp_dv[i + 8 * nb] = !serr && !perr;
                last_pd = data;
            end
            evq.push_back('{i + 8 * nb, last_pd});
            pos = i + 8 * nb + 1;
        end
    endtask

    task automatic check_cycle(input int m);
        ev_t ev;
        check("ce", 32'(bus.CounterEnable), 32'(exp_ce[m]));
        check("dv", 32'(bus.DataValid), 32'(exp_dv[m]));
        check("perr", 32'(bus.ParityError), 32'(exp_perr[m]));
        check("serr", 32'(bus.StopError), 32'(exp_serr[m]));
        if (evq.size() > 0 && evq[0].n == m) begin
            ev = evq.pop_front();
            check("pdata", 32'(bus.P_DATA), 32'(ev.pd));
        end
    endtask

    initial begin
        bus.RX_IN      = 1'b1;
        bus.ParityEn   = 1'b0;
        bus.ParityType = 1'b0;

        // Directed frames.
        cur_pe = 0; cur_pt = 0;
        add_idle(6);
        add_frame(8'h55, 0, 1, -1, 0);
        add_idle(6);
        cur_pe = 1; cur_pt = 0;
        add_idle(4);
        add_frame(8'hA3, 0, 1, -1, 0);
        add_idle(5);
        add_frame(8'hA3, 1, 1, -1, 0);
        add_idle(5);
        cur_pt = 1;
        add_idle(4);
        add_frame(8'h00, 0, 0, -1, 0);
        add_idle(5);
        add_frame(8'h5A, 0, 1, -1, 0);
        add_idle(5);
        cur_pe = 0; cur_pt = 0;
        add_idle(4);
        // Single inverted cycle seen at EdgeCounter 4 of data bit 3.
        add_frame(8'h0F, 0, 1, 4, 5);
        add_idle(5);
        add_frame(8'h12, 0, 1, -1, 0);
        add_frame(8'h34, 0, 1, -1, 0);
        add_idle(8);

        // Randomized frames with occasional parity/stop faults.
        for (int f = 0; f < 12; f++) begin
            cur_pe = 1'($urandom_range(0, 1));
            cur_pt = 1'($urandom_range(0, 1));
            add_idle($urandom_range(4, 12));
            add_frame(8'($urandom), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 4) != 0), -1, 0);
        end

        // Two-cycle low pulse on an idle line, no parity.
        cur_pe = 0; cur_pt = 0;
        add_idle(20);
        add_cycles(1'b0, 2);
        add_idle(100);
        add_frame(8'h3C, 0, 1, -1, 0);
        add_idle(10);

        run_model();

        #3 RST = 1'b0;
        #1;
        check("rst_ce", 32'(bus.CounterEnable), 32'd0);
        check("rst_dv", 32'(bus.DataValid), 32'd0);
        check("rst_pdata", 32'(bus.P_DATA), 32'd0);
        check("rst_perr", 32'(bus.ParityError), 32'd0);
        check("rst_serr", 32'(bus.StopError), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int n = 0; n < wave_rx.size(); n++) begin
            @(negedge CLK);
            if (n > 0) check_cycle(n - 1);
            bus.RX_IN      = wave_rx[n];
            bus.ParityEn   = wave_pe[n];
            bus.ParityType = wave_pt[n];
        end
        @(negedge CLK);
        check_cycle(wave_rx.size() - 1);
        check("events_left", 32'(evq.size()), 32'd0);

        // Mid-frame asynchronous reset.
        check("pdata_pre_rst", 32'(bus.P_DATA), 32'h3C);
        bus.RX_IN = 1'b0;
        repeat (30) @(negedge CLK);
        check("ce_mid_frame", 32'(bus.CounterEnable), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("arst_ce", 32'(bus.CounterEnable), 32'd0);
        check("arst_dv", 32'(bus.DataValid), 32'd0);
        check("arst_pdata", 32'(bus.P_DATA), 32'd0);
        check("arst_perr", 32'(bus.ParityError), 32'd0);
        check("arst_serr", 32'(bus.StopError), 32'd0);
        repeat (3) @(negedge CLK);
        check("arst_hold_ce", 32'(bus.CounterEnable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
